// File: rtl/inst_rom_pkg.sv
// inst_rom_pkg: shared bus types, the fetch NOP constant and the loader state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro: INST_ROM_CHECKSUM_EN adds the S_SUM loader state.
package inst_rom_pkg;

  typedef logic [31:0] InstBus;
  typedef logic [31:0] InstAddrBus;

  // addi x0, x0, 0 -- returned for fetches outside the loaded program
  localparam InstBus InstNop = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
`ifdef INST_ROM_CHECKSUM_EN
    S_SUM  = 2'd2,
`endif
    S_DATA = 2'd1,
    S_RUN  = 2'd3
  } load_state_e;

endpackage

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: turns a byte stream (4-byte LE word count, then LE words) into memory writes.
// Latency: a word's write strobe is combinational with the acceptance of its 4th byte.
// Backpressure: accepts one byte per cycle until loading completes, then refuses all bytes.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   load_valid_i/byte_i byte stream in; load_ready_o high while loading
//   cpu_hold_o          high until the program is fully loaded
//   overflow_o          sticky: a word landed beyond the memory depth and was dropped
//   load_err_o          one-cycle pulse on checksum mismatch (0 without INST_ROM_CHECKSUM_EN)
//   we_o/waddr_o/wdata_o write port toward the storage array
//   n_words_o           loaded word count, used to bound fetches
// Optional feature macro: INST_ROM_CHECKSUM_EN (trailing checksum byte, S_SUM state).
module inst_rom_loader
  import inst_rom_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid_i,
  input  logic [7:0]            load_byte_i,
  output logic                  load_ready_o,
  output logic                  cpu_hold_o,
  output logic                  overflow_o,
  output logic                  load_err_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output InstBus                wdata_o,
  output InstAddrBus            n_words_o
);

  // State reached once the last header/data byte is taken
`ifdef INST_ROM_CHECKSUM_EN
  localparam load_state_e LoadDone = S_SUM;
`else
  localparam load_state_e LoadDone = S_RUN;
`endif

  load_state_e state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] asm_q, asm_d;       // first three bytes of the word in flight
  InstAddrBus  n_q, n_d;
  InstAddrBus  waddr_q, waddr_d;   // also serves as the count of words received
  logic        overflow_q, overflow_d;
`ifdef INST_ROM_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  sum_next;
  logic        err_q, err_d;
`endif

  logic   accept;
  logic   last_byte;
  logic   in_range;
  InstBus full_word;

  assign accept    = load_valid_i && load_ready_o;
  assign last_byte = (byte_cnt_q == 2'd3);
  assign full_word = {load_byte_i, asm_q};
  // Out-of-depth words are dropped rather than wrapped onto low addresses
  assign in_range  = ((waddr_q >> ADDR_WIDTH) == '0);
`ifdef INST_ROM_CHECKSUM_EN
  assign sum_next  = sum_q + load_byte_i;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_LEN;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      n_q        <= '0;
      waddr_q    <= '0;
      overflow_q <= 1'b0;
`ifdef INST_ROM_CHECKSUM_EN
      sum_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      n_q        <= n_d;
      waddr_q    <= waddr_d;
      overflow_q <= overflow_d;
`ifdef INST_ROM_CHECKSUM_EN
      sum_q      <= sum_d;
      err_q      <= err_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    n_d        = n_q;
    waddr_d    = waddr_q;
    overflow_d = overflow_q;
`ifdef INST_ROM_CHECKSUM_EN
    sum_d      = sum_q;
    err_d      = 1'b0;
`endif
    if (accept) begin
      case (state_q)
        S_LEN, S_DATA: begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0:    asm_d[7:0]   = load_byte_i;
            2'd1:    asm_d[15:8]  = load_byte_i;
            2'd2:    asm_d[23:16] = load_byte_i;
            default: ;
          endcase
`ifdef INST_ROM_CHECKSUM_EN
          sum_d = sum_next;
`endif
          if (last_byte) begin
            if (state_q == S_LEN) begin
              n_d     = full_word;
              state_d = (full_word != '0) ? S_DATA : LoadDone;
            end else begin
              if (!in_range) overflow_d = 1'b1;
              waddr_d = waddr_q + 32'd1;
              if (waddr_q + 32'd1 == n_q) state_d = LoadDone;
            end
          end
        end
`ifdef INST_ROM_CHECKSUM_EN
        S_SUM: begin
          if (sum_next == 8'd0) begin
            state_d = S_RUN;
          end else begin
            // Bad image: drop it and wait for the host to resend from the header
            err_d      = 1'b1;
            state_d    = S_LEN;
            n_d        = '0;
            waddr_d    = '0;
            byte_cnt_d = '0;
            asm_d      = '0;
            sum_d      = '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    load_ready_o = (state_q != S_RUN);
    cpu_hold_o   = (state_q != S_RUN);
    we_o         = accept && (state_q == S_DATA) && last_byte && in_range;
    waddr_o      = waddr_q[ADDR_WIDTH-1:0];
    wdata_o      = full_word;
    n_words_o    = n_q;
    overflow_o   = overflow_q;
`ifdef INST_ROM_CHECKSUM_EN
    load_err_o   = err_q;
`else
    load_err_o   = 1'b0;
`endif
  end

endmodule

// File: rtl/inst_rom.sv
// inst_rom: instruction memory for the fetch port, filled from a byte stream before the core runs.
// Latency: fetch data is combinational from rom_addr_i; a written word is readable the next cycle.
// Backpressure: none on fetch; the byte stream is refused once the program is loaded.
//
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   rom_ce_i/rom_addr_i/rom_data_o fetch request (byte address) and instruction word
//   load_valid_i/load_byte_i/load_ready_o  program byte stream
//   cpu_hold_o                     holds the core in reset until loading completes
//   overflow_o, load_err_o         load status flags
// Optional feature macro: INST_ROM_CHECKSUM_EN (trailing checksum byte on the load stream).
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rom_ce_i,
  input  InstAddrBus rom_addr_i,
  output InstBus     rom_data_o,
  input  logic       load_valid_i,
  input  logic [7:0] load_byte_i,
  output logic       load_ready_o,
  output logic       cpu_hold_o,
  output logic       overflow_o,
  output logic       load_err_o
);

  localparam int Depth = 1 << ADDR_WIDTH;

  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  InstBus                wdata;
  InstAddrBus            n_words;
  InstAddrBus            word_addr;

  InstBus mem [Depth];

  inst_rom_loader #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_loader (
    .clk          (clk),
    .rst          (rst),
    .load_valid_i (load_valid_i),
    .load_byte_i  (load_byte_i),
    .load_ready_o (load_ready_o),
    .cpu_hold_o   (cpu_hold_o),
    .overflow_o   (overflow_o),
    .load_err_o   (load_err_o),
    .we_o         (we),
    .waddr_o      (waddr),
    .wdata_o      (wdata),
    .n_words_o    (n_words)
  );

  // Contents survive reset; only the loader state is cleared
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Byte offset within the word is ignored
  assign word_addr = rom_addr_i >> 2;

  always_comb begin
    rom_data_o = '0;
    if (rom_ce_i) begin
      if ((word_addr >= n_words) || ((word_addr >> ADDR_WIDTH) != '0)) begin
        rom_data_o = InstNop;
      end else begin
        rom_data_o = mem[word_addr[ADDR_WIDTH-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_inst_rom.sv
// tb_inst_rom: directed bench for inst_rom (default depth and a 4-word instance).
module tb_inst_rom;

  logic        clk;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] data_b, data_s;
  logic        vld, sel;
  logic        vld_b, vld_s;
  logic [7:0]  ld_byte;
  logic        rdy_b, rdy_s, hold_b, hold_s, ovf_b, ovf_s, err_b, err_s;
  logic        hold_cur, err_cur;

  int errors = 0;
  int checks = 0;

  logic [31:0] prog_q[$];
`ifdef INST_ROM_CHECKSUM_EN
  logic [7:0]  chk_flip;
  logic        exp_ok;
`endif

  assign vld_b    = vld && !sel;
  assign vld_s    = vld && sel;
  assign hold_cur = sel ? hold_s : hold_b;
  assign err_cur  = sel ? err_s : err_b;

  inst_rom u_big (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce),
    .rom_addr_i   (rom_addr),
    .rom_data_o   (data_b),
    .load_valid_i (vld_b),
    .load_byte_i  (ld_byte),
    .load_ready_o (rdy_b),
    .cpu_hold_o   (hold_b),
    .overflow_o   (ovf_b),
    .load_err_o   (err_b)
  );

  inst_rom #(.ADDR_WIDTH(2)) u_small (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce),
    .rom_addr_i   (rom_addr),
    .rom_data_o   (data_s),
    .load_valid_i (vld_s),
    .load_byte_i  (ld_byte),
    .load_ready_o (rdy_s),
    .cpu_hold_o   (hold_s),
    .overflow_o   (ovf_s),
    .load_err_o   (err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp_b);
    rom_ce   = 1'b1;
    rom_addr = addr;
    #1;
    chk(tag, data_b, exp_b);
  endtask

  // Sends header + prog_q (+ checksum byte) to the selected instance, optionally with idle gaps
  task automatic load_prog(input bit to_small, input int gap);
    logic [7:0]  bytes[$];
    logic [7:0]  sum;
    logic [31:0] w;
    int          n;
    n   = prog_q.size();
    sel = to_small;
    for (int k = 0; k < 4; k++) bytes.push_back(8'(n >> (8 * k)));
    for (int j = 0; j < n; j++) begin
      w = prog_q[j];
      for (int k = 0; k < 4; k++) bytes.push_back(w[8*k +: 8]);
    end
    sum = '0;
    for (int i = 0; i < bytes.size(); i++) sum = sum + bytes[i];
`ifdef INST_ROM_CHECKSUM_EN
    bytes.push_back((8'd0 - sum) ^ chk_flip);
`endif
    for (int i = 0; i < bytes.size(); i++) begin
      @(negedge clk);
      if (i == bytes.size() - 1) chk("hold_before_last", {31'd0, hold_cur}, 32'd1);
      vld     = 1'b1;
      ld_byte = bytes[i];
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        vld = 1'b0;
      end
    end
    @(negedge clk);
    vld = 1'b0;
`ifdef INST_ROM_CHECKSUM_EN
    chk("hold_after_last", {31'd0, hold_cur}, {31'd0, !exp_ok});
    chk("err_after_last", {31'd0, err_cur}, {31'd0, !exp_ok});
`else
    chk("hold_after_last", {31'd0, hold_cur}, 32'd0);
`endif
  endtask

  initial begin
    rst      = 1'b1;
    vld      = 1'b0;
    sel      = 1'b0;
    ld_byte  = '0;
    rom_ce   = 1'b0;
    rom_addr = '0;
`ifdef INST_ROM_CHECKSUM_EN
    chk_flip = 8'h00;
    exp_ok   = 1'b1;
`endif

    // Reset values
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, rdy_b}, 32'd1);
    chk("rst_hold", {31'd0, hold_b}, 32'd1);
    chk("rst_ovf", {31'd0, ovf_b}, 32'd0);
    chk("rst_err", {31'd0, err_b}, 32'd0);
    chk("rst_small_hold", {31'd0, hold_s}, 32'd1);
    rst = 1'b1;
    fetch("rst_fetch_nop", 32'h0, 32'h0000_0013);

    // N=2 program, then fetch patterns
    prog_q = '{32'h0010_0093, 32'h0020_0113};
    load_prog(1'b0, 0);
    fetch("fetch_0", 32'h0, 32'h0010_0093);
    fetch("fetch_4", 32'h4, 32'h0020_0113);
    fetch("fetch_8_nop", 32'h8, 32'h0000_0013);
    fetch("fetch_5_lane", 32'h5, 32'h0020_0113);
    fetch("fetch_high_nop", 32'h0000_1000, 32'h0000_0013);
    fetch("fetch_top_bit_nop", 32'h8000_0000, 32'h0000_0013);
    rom_ce = 1'b0;
    #1;
    chk("ce_off_zero", data_b, 32'h0);
    chk("run_ready", {31'd0, rdy_b}, 32'd0);
    chk("run_ovf", {31'd0, ovf_b}, 32'd0);
    // Bytes offered while running must not disturb anything
    @(negedge clk);
    vld = 1'b1;
    ld_byte = 8'hFF;
    repeat (4) @(negedge clk);
    vld = 1'b0;
    fetch("run_ignores_bytes", 32'h0, 32'h0010_0093);
    chk("run_still_released", {31'd0, hold_b}, 32'd0);

    // Reset drops N: old contents stay but are no longer served
    do_reset();
    fetch("after_rst_nop", 32'h0, 32'h0000_0013);

    // Empty program
    prog_q = {};
    load_prog(1'b0, 0);
    fetch("n0_fetch_nop", 32'h0, 32'h0000_0013);

    // Reset in the middle of a load, then a full reload
    do_reset();
    sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vld     = 1'b1;
      ld_byte = (i == 0) ? 8'h01 : 8'hA5;
    end
    @(negedge clk);
    vld = 1'b0;
    chk("partial_hold", {31'd0, hold_b}, 32'd1);
    do_reset();
    chk("partial_rst_ready", {31'd0, rdy_b}, 32'd1);
    prog_q = '{32'hDEAD_BEEF};
    load_prog(1'b0, 0);
    fetch("reload_fetch", 32'h0, 32'hDEAD_BEEF);
    fetch("reload_fetch_4_nop", 32'h4, 32'h0000_0013);

    // Same program with idle cycles between bytes
    do_reset();
    prog_q = '{32'h1234_5678};
    load_prog(1'b0, 0);
    do_reset();
    prog_q = '{32'hDEAD_BEEF};
    load_prog(1'b0, 2);
    fetch("gap_fetch", 32'h0, 32'hDEAD_BEEF);

    // Depth-4 instance, 5-word program: last word dropped, load still completes
    do_reset();
    prog_q = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
    load_prog(1'b1, 0);
    chk("small_ovf", {31'd0, ovf_s}, 32'd1);
    chk("big_no_ovf", {31'd0, ovf_b}, 32'd0);
    rom_ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rom_addr = 32'(4 * i);
      #1;
      chk("small_word", data_s, 32'hA000_0000 + 32'(i));
    end
    rom_addr = 32'h10;
    #1;
    chk("small_dropped_nop", data_s, 32'h0000_0013);

`ifdef INST_ROM_CHECKSUM_EN
    // N=1 word 1: checksum 0xFE accepted, 0x00 rejected
    do_reset();
    prog_q   = '{32'h0000_0001};
    chk_flip = 8'h00;
    exp_ok   = 1'b1;
    load_prog(1'b0, 0);
    fetch("sum_ok_fetch", 32'h0, 32'h0000_0001);
    do_reset();
    chk_flip = 8'hFE;
    exp_ok   = 1'b0;
    load_prog(1'b0, 0);
    chk("sum_bad_ready", {31'd0, rdy_b}, 32'd1);
    @(negedge clk);
    chk("sum_err_pulse_end", {31'd0, err_b}, 32'd0);
    chk("sum_bad_hold", {31'd0, hold_b}, 32'd1);
    fetch("sum_bad_nop", 32'h0, 32'h0000_0013);
    // Host resends without a reset
    prog_q   = '{32'h0000_0042};
    chk_flip = 8'h00;
    exp_ok   = 1'b1;
    load_prog(1'b0, 0);
    fetch("sum_retry_fetch", 32'h0, 32'h0000_0042);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
